// File: rtl/m_006_updown_mod_counter.sv
// m_006_updown_mod_counter: up/down modulo counter, range 0..max_i,
// wrap or saturate at the bounds, with event pulse and sticky flag.
//
// Ports:
//   clk_i      : clock, rising edge
//   n_rst_i    : async active-low reset
//   en_i       : count enable, one step per cycle
//   up_i       : 1 = increment, 0 = decrement
//   sat_i      : 0 = wrap, 1 = saturate at bound
//   clr_i      : sync clear of count, event and flag
//   load_i     : sync load of min(load_val_i, max_i)
//   load_val_i : load value
//   max_i      : inclusive upper bound
//   cnt_o      : registered count
//   tc_o       : next enabled edge is a boundary event
//   evt_o      : one-cycle boundary-event pulse
//   ovf_o      : sticky overflow/underflow flag
module m_006_updown_mod_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             n_rst_i,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             sat_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic [WIDTH-1:0] max_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             tc_o,
  output logic             evt_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             evt_q, evt_d;
  logic             ovf_q, ovf_d;

  logic at_top;
  logic at_zero;
  logic above;

  // Bounds are compared before +/-1, so max_i at all-ones
  // never needs a carry bit.
  assign at_top  = (cnt_q >= max_i);
  assign at_zero = (cnt_q == '0);
  assign above   = (cnt_q > max_i);

  always_comb begin
    cnt_d = cnt_q;
    evt_d = 1'b0;
    ovf_d = ovf_q;
    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (load_i) begin
      cnt_d = (load_val_i > max_i) ? max_i : load_val_i;
    end else if (en_i) begin
      if (up_i) begin
        if (at_top) begin
          evt_d = 1'b1;
          ovf_d = 1'b1;
          cnt_d = sat_i ? max_i : '0;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else begin
        // max_i lowered below the count: snap down quietly
        if (above) begin
          cnt_d = max_i;
        end else if (at_zero) begin
          evt_d = 1'b1;
          ovf_d = 1'b1;
          cnt_d = sat_i ? '0 : max_i;
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      cnt_q <= '0;
      evt_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      evt_q <= evt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign evt_o = evt_q;
  assign ovf_o = ovf_q;
  assign tc_o  = en_i & (up_i ? at_top : at_zero);

endmodule

// File: tb/tb_m_006_updown_mod_counter.sv
// tb_m_006_updown_mod_counter: directed vectors with a queued
// scoreboard; a monitor pops and checks each cycle's response.
module tb_m_006_updown_mod_counter;

  localparam int W = 8;

  logic         clk;
  logic         n_rst;
  logic         en, up, sat, clr, ld;
  logic [W-1:0] lv, mx;
  logic [W-1:0] cnt;
  logic         tc, evt, ovf;

  m_006_updown_mod_counter #(.WIDTH(W)) dut (
    .clk_i      (clk),
    .n_rst_i    (n_rst),
    .en_i       (en),
    .up_i       (up),
    .sat_i      (sat),
    .clr_i      (clr),
    .load_i     (ld),
    .load_val_i (lv),
    .max_i      (mx),
    .cnt_o      (cnt),
    .tc_o       (tc),
    .evt_o      (evt),
    .ovf_o      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         tc;
    logic [W-1:0] cnt;
    logic         evt;
    logic         ovf;
    string        nm;
  } item_t;

  item_t q[$];
  int n_chk  = 0;
  int n_pass = 0;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endfunction

  // Drive one cycle of inputs and queue the expected response:
  // e_tc before the edge, e_cnt/e_evt/e_ovf after it.
  task automatic vec(input logic i_en, i_up, i_sat, i_clr, i_ld,
                     input logic [W-1:0] i_lv, i_mx,
                     input logic e_tc,
                     input logic [W-1:0] e_cnt,
                     input logic e_evt, e_ovf,
                     input string nm);
    item_t it;
    @(negedge clk);
    en = i_en; up = i_up; sat = i_sat; clr = i_clr; ld = i_ld;
    lv = i_lv; mx = i_mx;
    it.tc = e_tc; it.cnt = e_cnt; it.evt = e_evt; it.ovf = e_ovf;
    it.nm = nm;
    q.push_back(it);
  endtask

  // Monitor
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() != 0) begin
        it = q.pop_front();
        chk({it.nm, ".tc"}, 32'(tc), 32'(it.tc));
        @(posedge clk);
        #1;
        chk({it.nm, ".cnt"}, 32'(cnt), 32'(it.cnt));
        chk({it.nm, ".evt"}, 32'(evt), 32'(it.evt));
        chk({it.nm, ".ovf"}, 32'(ovf), 32'(it.ovf));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got %0d queued expected 0", q.size());
    $fatal(1, "timeout");
  end

  initial begin
    n_rst = 1'b0;
    en = 0; up = 1; sat = 0; clr = 0; ld = 0;
    lv = '0; mx = 8'd15;
    #22;
    chk("rst.cnt", 32'(cnt), 0);
    chk("rst.evt", 32'(evt), 0);
    chk("rst.ovf", 32'(ovf), 0);
    @(negedge clk);
    n_rst = 1'b1;

    // Up, wrap, max 15: 1..15, 0 (event), 1
    for (int k = 1; k <= 17; k++)
      vec(1, 1, 0, 0, 0, 8'd0, 8'd15,
          k == 16, W'(k % 16), k == 16, k >= 16, "up_wrap");

    // Load 2, then down saturate with max 9
    vec(0, 0, 1, 0, 1, 8'd2, 8'd9, 0, 8'd2, 0, 1, "load2");
    vec(1, 0, 1, 0, 0, 8'd0, 8'd9, 0, 8'd1, 0, 1, "dn_sat1");
    vec(1, 0, 1, 0, 0, 8'd0, 8'd9, 0, 8'd0, 0, 1, "dn_sat0");
    vec(1, 0, 1, 0, 0, 8'd0, 8'd9, 1, 8'd0, 1, 1, "dn_satA");
    vec(1, 0, 1, 0, 0, 8'd0, 8'd9, 1, 8'd0, 1, 1, "dn_satB");

    // Priority
    vec(0, 1, 0, 0, 1, 8'd5, 8'd9, 0, 8'd5, 0, 1, "load5");
    vec(1, 1, 0, 1, 1, 8'd7, 8'd9, 0, 8'd0, 0, 0, "clr_all");
    vec(1, 1, 0, 0, 1, 8'd12, 8'd9, 0, 8'd9, 0, 0, "load_clip");
    vec(0, 1, 0, 0, 0, 8'd0, 8'd9, 0, 8'd9, 0, 0, "hold");

    // Run-time max lowered below the count
    vec(0, 1, 0, 0, 1, 8'd12, 8'd15, 0, 8'd12, 0, 0, "load12");
    vec(1, 1, 0, 0, 0, 8'd0, 8'd7, 1, 8'd0, 1, 1, "max_up");
    vec(0, 1, 0, 0, 1, 8'd12, 8'd15, 0, 8'd12, 0, 1, "reload12");
    vec(1, 0, 0, 0, 0, 8'd0, 8'd7, 0, 8'd7, 0, 1, "max_dn");
    vec(1, 0, 0, 0, 0, 8'd0, 8'd7, 0, 8'd6, 0, 1, "dn6");

    // Async reset between edges at cnt 6, ovf 1
    @(negedge clk);
    en = 0;
    #2;
    n_rst = 1'b0;
    #1;
    chk("arst.cnt", 32'(cnt), 0);
    chk("arst.evt", 32'(evt), 0);
    chk("arst.ovf", 32'(ovf), 0);
    @(posedge clk);
    #1;
    chk("arst_hold.cnt", 32'(cnt), 0);
    @(negedge clk);
    n_rst = 1'b1;

    // Full width, max 255
    vec(1, 0, 0, 0, 0, 8'd0, 8'd255, 1, 8'd255, 1, 1, "fw_dn");
    vec(1, 1, 0, 0, 0, 8'd0, 8'd255, 1, 8'd0, 1, 1, "fw_up");

    // max 0: every enabled step is an event
    vec(1, 1, 0, 0, 0, 8'd0, 8'd0, 1, 8'd0, 1, 1, "m0_up");
    vec(1, 0, 1, 0, 0, 8'd0, 8'd0, 1, 8'd0, 1, 1, "m0_dn");
    vec(0, 0, 0, 0, 0, 8'd0, 8'd0, 0, 8'd0, 0, 1, "m0_hold");

    // Saturate up at bound: event every cycle
    vec(0, 1, 1, 0, 1, 8'd3, 8'd3, 0, 8'd3, 0, 1, "load3");
    vec(1, 1, 1, 0, 0, 8'd0, 8'd3, 1, 8'd3, 1, 1, "sat_upA");
    vec(1, 1, 1, 0, 0, 8'd0, 8'd3, 1, 8'd3, 1, 1, "sat_upB");
    vec(0, 1, 1, 1, 0, 8'd0, 8'd3, 0, 8'd0, 0, 0, "clr");

    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("drain", 32'(q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
